// File: rtl/rv32i_io_arbiter.sv
// rtl/rv32i_io_arbiter.sv - two-requester round-robin IO bus arbiter/sequencer
// Optional owner lock (ports lock0/lock1) enabled by defining IO_ARB_LOCK_EN.
module rv32i_io_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef IO_ARB_LOCK_EN
  input  logic                  lock0,
  input  logic                  lock1,
`endif
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  io_we,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic [DATA_WIDTH-1:0] io_wdata,
  input  logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  w_arb;
  logic                  w_win;
  logic                  w_upd_last;

  // Arbitration is only open outside ACCESS, so a requester's req during its own gnt is ignored.
  always_comb begin
    w_arb      = (r_state != S_ACCESS) && (req0 || req1);
    w_win      = (req0 && req1) ? ~r_last : req1;
    w_upd_last = 1'b1;
`ifdef IO_ARB_LOCK_EN
    if (r_state == S_RESP && (r_owner ? (lock1 && req1) : (lock0 && req0))) begin
      w_win      = r_owner;
      w_upd_last = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_arb) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = w_arb ? S_ACCESS : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_arb) begin
        r_owner <= w_win;
        r_we    <= w_win ? we1 : we0;
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
        if (w_upd_last) r_last <= w_win;
      end
      if (r_state == S_RESP) begin
        if (r_owner) r_rdata1 <= io_rdata;
        else         r_rdata0 <= io_rdata;
      end
    end
  end

  // Read data passes straight through in RESP; otherwise each side keeps its last response.
  always_comb begin
    gnt0     = (r_state == S_ACCESS) && !r_owner;
    gnt1     = (r_state == S_ACCESS) &&  r_owner;
    rvalid0  = (r_state == S_RESP)   && !r_owner;
    rvalid1  = (r_state == S_RESP)   &&  r_owner;
    rdata0   = rvalid0 ? io_rdata : r_rdata0;
    rdata1   = rvalid1 ? io_rdata : r_rdata1;
    io_we    = (r_state == S_ACCESS) && r_we;
    io_addr  = r_addr;
    io_wdata = r_wdata;
    busy     = (r_state != S_IDLE);
  end

endmodule
